// File: rtl/video_fetch_ctrl.sv
// Per-line video fetch sequencer: requests a DRAM burst inside the horizontal fetch window,
// counts delivered words against a mode-dependent target and flags underruns per frame.
module video_fetch_ctrl #(
    parameter int unsigned WORDS_PENT = 32,
    parameter int unsigned WORDS_ATM  = 80,
    parameter int unsigned WORDS_TEXT = 80
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_fetch_start,
    input  logic       i_fetch_end,
    input  logic       i_line_start,
    input  logic       i_frame_start,
    input  logic       i_vpix,
    input  logic       i_mode_atm_n_pent,
    input  logic       i_mode_a_text,
    input  logic       i_video_next,
    output logic       o_go,
    output logic [6:0] o_word_cnt,
    output logic [8:0] o_line_num,
    output logic       o_busy,
    output logic       o_underrun,
    output logic       o_frame_underrun
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StDone  = 2'd2
    } state_t;

    state_t     r_state, w_state_d;
    logic       r_go, w_go_d;
    logic       r_busy, w_busy_d;
    logic [6:0] r_word_cnt, w_word_cnt_d;
    logic [8:0] r_line_num, w_line_num_d;
    logic       r_underrun, w_underrun_d;
    logic       r_frame_underrun, w_frame_underrun_d;
    logic [6:0] r_target, w_target_d;

    logic [6:0] w_mode_target;
    logic [6:0] w_cnt_inc;
    logic [8:0] w_line_inc;
    logic       w_complete;

    always_comb begin
        if (i_mode_a_text) begin
            w_mode_target = 7'(WORDS_TEXT);
        end else if (i_mode_atm_n_pent) begin
            w_mode_target = 7'(WORDS_ATM);
        end else begin
            w_mode_target = 7'(WORDS_PENT);
        end
    end

    assign w_cnt_inc  = r_word_cnt + {6'd0, i_video_next};
    assign w_line_inc = (r_line_num == 9'd511) ? r_line_num : r_line_num + 9'd1;
    assign w_complete = i_video_next && (r_word_cnt == r_target - 7'd1);

    always_comb begin
        w_state_d          = r_state;
        w_go_d             = r_go;
        w_busy_d           = r_busy;
        w_word_cnt_d       = r_word_cnt;
        w_line_num_d       = r_line_num;
        w_underrun_d       = r_underrun;
        w_frame_underrun_d = r_frame_underrun;
        w_target_d         = r_target;

        // frame_start overrides everything, including a coincident underrun
        if (i_frame_start) begin
            w_state_d          = StIdle;
            w_go_d             = 1'b0;
            w_busy_d           = 1'b0;
            w_word_cnt_d       = 7'd0;
            w_line_num_d       = 9'd0;
            w_frame_underrun_d = r_underrun;
            w_underrun_d       = 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_fetch_start && i_vpix) begin
                        w_state_d    = StFetch;
                        w_go_d       = 1'b1;
                        w_busy_d     = 1'b1;
                        w_word_cnt_d = 7'd0;
                        w_target_d   = w_mode_target;
                    end
                end
                StFetch: begin
                    if (w_complete) begin
                        w_state_d    = StDone;
                        w_go_d       = 1'b0;
                        w_busy_d     = 1'b0;
                        w_word_cnt_d = r_target;
                        w_line_num_d = w_line_inc;
                    end else if (i_fetch_end) begin
                        w_state_d    = StDone;
                        w_go_d       = 1'b0;
                        w_busy_d     = 1'b0;
                        w_word_cnt_d = w_cnt_inc;
                        w_line_num_d = w_line_inc;
                        w_underrun_d = 1'b1;
                    end else begin
                        w_word_cnt_d = w_cnt_inc;
                    end
                end
                StDone: begin
                    w_go_d   = 1'b0;
                    w_busy_d = 1'b0;
                    if (i_line_start) begin
                        w_state_d = StIdle;
                    end
                end
                default: begin
                    w_state_d = StIdle;
                    w_go_d    = 1'b0;
                    w_busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= StIdle;
            r_go             <= 1'b0;
            r_busy           <= 1'b0;
            r_word_cnt       <= 7'd0;
            r_line_num       <= 9'd0;
            r_underrun       <= 1'b0;
            r_frame_underrun <= 1'b0;
            r_target         <= 7'd0;
        end else begin
            r_state          <= w_state_d;
            r_go             <= w_go_d;
            r_busy           <= w_busy_d;
            r_word_cnt       <= w_word_cnt_d;
            r_line_num       <= w_line_num_d;
            r_underrun       <= w_underrun_d;
            r_frame_underrun <= w_frame_underrun_d;
            r_target         <= w_target_d;
        end
    end

    assign o_go             = r_go;
    assign o_busy           = r_busy;
    assign o_word_cnt       = r_word_cnt;
    assign o_line_num       = r_line_num;
    assign o_underrun       = r_underrun;
    assign o_frame_underrun = r_frame_underrun;

endmodule

// File: tb/tb_video_fetch_ctrl.sv
// Directed bench for video_fetch_ctrl: hand-computed expectations checked with immediate asserts.
module tb_video_fetch_ctrl;

    logic       clk;
    logic       rst_n;
    logic       fetch_start, fetch_end, line_start, frame_start;
    logic       vpix, mode_atm_n_pent, mode_a_text, video_next;
    logic       go, busy, underrun, frame_underrun;
    logic [6:0] word_cnt;
    logic [8:0] line_num;

    int n_checks = 0;
    int n_fail   = 0;

    video_fetch_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_fetch_start     (fetch_start),
        .i_fetch_end       (fetch_end),
        .i_line_start      (line_start),
        .i_frame_start     (frame_start),
        .i_vpix            (vpix),
        .i_mode_atm_n_pent (mode_atm_n_pent),
        .i_mode_a_text     (mode_a_text),
        .i_video_next      (video_next),
        .o_go              (go),
        .o_word_cnt        (word_cnt),
        .o_line_num        (line_num),
        .o_busy            (busy),
        .o_underrun        (underrun),
        .o_frame_underrun  (frame_underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_fetch_start();
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
    endtask

    task automatic pulse_line_start();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic words(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            video_next = 1'b1;
            tick();
            video_next = 1'b0;
            repeat (gap) tick();
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        fetch_start     = 1'b0;
        fetch_end       = 1'b0;
        line_start      = 1'b0;
        frame_start     = 1'b0;
        vpix            = 1'b0;
        mode_atm_n_pent = 1'b0;
        mode_a_text     = 1'b0;
        video_next      = 1'b0;

        #3;
        check("rst_go", go, 0);
        check("rst_busy", busy, 0);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_line_num", line_num, 0);
        check("rst_underrun", underrun, 0);
        check("rst_frame_underrun", frame_underrun, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Pentagon line, 32 words spaced 4 clocks
        vpix = 1'b1;
        pulse_fetch_start();
        check("pent_go_rise", go, 1);
        check("pent_busy", busy, 1);
        check("pent_cnt0", word_cnt, 0);
        words(31, 3);
        check("pent_go_before_last", go, 1);
        check("pent_cnt31", word_cnt, 31);
        words(1, 0);
        check("pent_go_fall", go, 0);
        check("pent_busy_fall", busy, 0);
        check("pent_cnt32", word_cnt, 32);
        check("pent_line1", line_num, 1);
        check("pent_underrun", underrun, 0);
        words(2, 0);
        check("done_cnt_hold", word_cnt, 32);

        // fetch_start in DONE without line_start
        pulse_fetch_start();
        tick();
        check("done_fs_go", go, 0);
        check("done_fs_line", line_num, 1);

        // fetch_start with vpix=0
        pulse_line_start();
        vpix = 1'b0;
        pulse_fetch_start();
        tick();
        check("novpix_go", go, 0);
        check("novpix_busy", busy, 0);
        check("novpix_line", line_num, 1);

        // ATM text underrun: 50 words, then fetch_end
        vpix        = 1'b1;
        mode_a_text = 1'b1;
        pulse_fetch_start();
        check("text_go", go, 1);
        words(25, 1);
        pulse_line_start();
        check("text_ls_busy", busy, 1);
        words(25, 1);
        check("text_go_pre_end", go, 1);
        fetch_end = 1'b1;
        tick();
        fetch_end = 1'b0;
        check("text_go_fall", go, 0);
        check("text_cnt50", word_cnt, 50);
        check("text_underrun", underrun, 1);
        check("text_line2", line_num, 2);
        pulse_frame_start();
        check("frame_fu", frame_underrun, 1);
        check("frame_underrun_clr", underrun, 0);
        check("frame_line0", line_num, 0);
        check("frame_cnt0", word_cnt, 0);

        // ATM graphic: fetch_end coincident with 80th word
        mode_a_text     = 1'b0;
        mode_atm_n_pent = 1'b1;
        pulse_fetch_start();
        words(79, 0);
        check("atm_go_79", go, 1);
        check("atm_cnt79", word_cnt, 79);
        video_next = 1'b1;
        fetch_end  = 1'b1;
        tick();
        video_next = 1'b0;
        fetch_end  = 1'b0;
        check("atm_cnt80", word_cnt, 80);
        check("atm_underrun", underrun, 0);
        check("atm_busy", busy, 0);
        check("atm_go", go, 0);
        check("atm_line1", line_num, 1);

        // mode switch mid-line: target latched as 32
        pulse_line_start();
        mode_atm_n_pent = 1'b0;
        pulse_fetch_start();
        words(10, 1);
        mode_atm_n_pent = 1'b1;
        words(21, 1);
        check("sw_go_31", go, 1);
        check("sw_cnt31", word_cnt, 31);
        words(1, 0);
        check("sw_cnt32", word_cnt, 32);
        check("sw_go_fall", go, 0);
        check("sw_line2", line_num, 2);

        // next line targets 80
        pulse_line_start();
        pulse_fetch_start();
        words(32, 0);
        check("nx_go_32", go, 1);
        check("nx_busy_32", busy, 1);
        words(48, 0);
        check("nx_cnt80", word_cnt, 80);
        check("nx_go_fall", go, 0);
        check("nx_line3", line_num, 3);

        // asynchronous reset mid-fetch
        pulse_line_start();
        pulse_fetch_start();
        words(20, 0);
        check("mid_cnt20", word_cnt, 20);
        check("mid_go", go, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_go", go, 0);
        check("arst_busy", busy, 0);
        check("arst_cnt", word_cnt, 0);
        check("arst_line", line_num, 0);
        check("arst_fu", frame_underrun, 0);
        tick();
        rst_n = 1'b1;
        tick();
        pulse_fetch_start();
        check("post_go", go, 1);
        check("post_cnt0", word_cnt, 0);
        words(1, 0);
        check("post_cnt1", word_cnt, 1);

        // frame_start in FETCH clears, coincident fetch_start ignored
        frame_start = 1'b1;
        fetch_start = 1'b1;
        tick();
        frame_start = 1'b0;
        fetch_start = 1'b0;
        check("fsf_go", go, 0);
        check("fsf_busy", busy, 0);
        check("fsf_fu", frame_underrun, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
